// File: rtl/riscv_pkg.sv
// Shared definitions for the integer pipeline stages: default widths,
// the hard-wired zero register address and common data typedefs.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REGS_WIDTH = 5;

    typedef logic [REGS_WIDTH-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_bank.sv
// Integer register storage: one synchronous write port, two asynchronous
// read ports, asynchronous clear, entry 0 permanently reading zero.
module reg_bank #(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int REGS_WIDTH = riscv_pkg::REGS_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  we_i,
    input  logic [REGS_WIDTH-1:0] waddr_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic [REGS_WIDTH-1:0] raddr1_i,
    output logic [XLEN-1:0]       rdata1_o,
    input  logic [REGS_WIDTH-1:0] raddr2_i,
    output logic [XLEN-1:0]       rdata2_o
);

    localparam int NREGS = 2 ** REGS_WIDTH;

    logic [XLEN-1:0] mem_q [NREGS];

    // NOTE: this array is built from flops, so it can take the asynchronous
    // clear; a RAM macro could not, and would need a sweep-clear instead.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: qualifies commits into the register bank, serves two
// registered read ports with write bypass, and counts committed writes.
module reg_writeback
    import riscv_pkg::*;
#(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int REGS_WIDTH = riscv_pkg::REGS_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  halt_i,
    input  logic [REGS_WIDTH-1:0] rd_addr_i,
    input  logic                  rd_write_en_i,
    input  logic [XLEN-1:0]       rd_data_i,
    input  logic [REGS_WIDTH-1:0] rs1_addr_i,
    input  logic                  rs1_read_en_i,
    input  logic [REGS_WIDTH-1:0] rs2_addr_i,
    input  logic                  rs2_read_en_i,
    output logic [XLEN-1:0]       rs1_data_o,
    output logic [XLEN-1:0]       rs2_data_o,
    output logic [31:0]           wb_count_o
);

    localparam logic [REGS_WIDTH-1:0] ZERO_ADDR = REGS_WIDTH'(REG_ZERO);

    logic            commit;
    logic [XLEN-1:0] bank_rd1, bank_rd2;
    logic [XLEN-1:0] rs1_data_d, rs1_data_q;
    logic [XLEN-1:0] rs2_data_d, rs2_data_q;
    logic [31:0]     wb_count_d, wb_count_q;

    // Halt deliberately does not gate this: in-flight instructions must retire.
    assign commit = rd_write_en_i && (rd_addr_i != ZERO_ADDR);

    reg_bank #(
        .XLEN       (XLEN),
        .REGS_WIDTH (REGS_WIDTH)
    ) u_bank (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .we_i     (commit),
        .waddr_i  (rd_addr_i),
        .wdata_i  (rd_data_i),
        .raddr1_i (rs1_addr_i),
        .rdata1_o (bank_rd1),
        .raddr2_i (rs2_addr_i),
        .rdata2_o (bank_rd2)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        wb_count_d = wb_count_q + (commit ? 32'd1 : 32'd0);

        if (rs1_read_en_i && !halt_i) begin
            if (rs1_addr_i == ZERO_ADDR)                 rs1_data_d = '0;
            else if (commit && (rd_addr_i == rs1_addr_i)) rs1_data_d = rd_data_i;
            else                                         rs1_data_d = bank_rd1;
        end

        if (rs2_read_en_i && !halt_i) begin
            if (rs2_addr_i == ZERO_ADDR)                 rs2_data_d = '0;
            else if (commit && (rd_addr_i == rs2_addr_i)) rs2_data_d = rd_data_i;
            else                                         rs2_data_d = bank_rd2;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            wb_count_q <= '0;
        end else begin
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign rs1_data_o = rs1_data_q;
    assign rs2_data_o = rs2_data_q;
    assign wb_count_o = wb_count_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback: vector table plus
// hand-written sequences for counter wrap and mid-cycle reset.
module tb_reg_writeback;

    logic        clk;
    logic        resetn;
    logic        halt;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic        rs1_en;
    logic [4:0]  rs2_addr;
    logic        rs2_en;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_count;

    int n_checks = 0;
    int n_fail   = 0;

    reg_writeback dut (
        .clk_i         (clk),
        .resetn_i      (resetn),
        .halt_i        (halt),
        .rd_addr_i     (rd_addr),
        .rd_write_en_i (rd_we),
        .rd_data_i     (rd_data),
        .rs1_addr_i    (rs1_addr),
        .rs1_read_en_i (rs1_en),
        .rs2_addr_i    (rs2_addr),
        .rs2_read_en_i (rs2_en),
        .rs1_data_o    (rs1_data),
        .rs2_data_o    (rs2_data),
        .wb_count_o    (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        halt;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        r1e;
        logic [4:0]  r1a;
        logic        r2e;
        logic [4:0]  r2a;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] expc;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic r1e, input logic [4:0] r1a, input logic r2e, input logic [4:0] r2a);
        halt = h; rd_we = we; rd_addr = wa; rd_data = wd;
        rs1_en = r1e; rs1_addr = r1a; rs2_en = r2e; rs2_addr = r2a;
    endtask

    // Apply inputs after a falling edge, let one rising edge pass, sample 1 ns later.
    task automatic step(input logic h, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic r1e, input logic [4:0] r1a, input logic r2e, input logic [4:0] r2a);
        @(negedge clk);
        drive(h, we, wa, wd, r1e, r1a, r2e, r2a);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] load_val(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0011;
    endfunction

    initial begin
        //          halt we  wa     wd            r1e r1a    r2e r2a    exp1          exp2          cnt
        vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         32'h0,         32'd1};
        vecs[1]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  1'b0, 5'd0,  32'hDEAD_BEEF, 32'h0,         32'd1};
        vecs[2]  = '{1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  1'b1, 5'd0,  32'hDEAD_BEEF, 32'h0,         32'd1};
        vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b0, 5'd0,  32'h0,         32'h0,         32'd1};
        vecs[4]  = '{1'b0, 1'b1, 5'd7,  32'h1234_5678, 1'b1, 5'd7,  1'b1, 5'd7,  32'h1234_5678, 32'h1234_5678, 32'd2};
        vecs[5]  = '{1'b0, 1'b1, 5'd9,  32'hA5A5_A5A5, 1'b1, 5'd9,  1'b1, 5'd5,  32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'd3};
        vecs[6]  = '{1'b1, 1'b1, 5'd3,  32'h0000_0011, 1'b1, 5'd3,  1'b1, 5'd7,  32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'd4};
        vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  1'b0, 5'd9,  32'h0000_0011, 32'hDEAD_BEEF, 32'd4};
        vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd3,  1'b1, 5'd9,  32'h0000_0011, 32'hA5A5_A5A5, 32'd4};
        vecs[9]  = '{1'b0, 1'b0, 5'd3,  32'h0000_0022, 1'b1, 5'd3,  1'b0, 5'd0,  32'h0000_0011, 32'hA5A5_A5A5, 32'd4};
        vecs[10] = '{1'b0, 1'b1, 5'd31, 32'hCAFE_F00D, 1'b1, 5'd31, 1'b1, 5'd30, 32'hCAFE_F00D, 32'h0,         32'd5};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, 5'd31, 32'h1234_5678, 32'hCAFE_F00D, 32'd5};

        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rs1", rs1_data, 32'h0);
        check("reset rs2", rs2_data, 32'h0);
        check("reset count", wb_count, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        for (int v = 0; v < 12; v++) begin
            step(vecs[v].halt, vecs[v].we, vecs[v].wa, vecs[v].wd,
                 vecs[v].r1e, vecs[v].r1a, vecs[v].r2e, vecs[v].r2a);
            check($sformatf("vec%0d rs1", v), rs1_data, vecs[v].exp1);
            check($sformatf("vec%0d rs2", v), rs2_data, vecs[v].exp2);
            check($sformatf("vec%0d count", v), wb_count, vecs[v].expc);
        end

        // Counter wrap: preload all-ones, then one commit.
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        #1;
        check("count preload", wb_count, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 5'd2, 32'h0000_0001, 1'b0, 5'd0, 1'b0, 5'd0);
        check("count wrap", wb_count, 32'h0);

        // Fill x1..x31, verify a sample, then reset mid-cycle with a commit pending.
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'b1, 5'(i), load_val(i), 1'b0, 5'd0, 1'b0, 5'd0);
        end
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd31);
        check("fill x1", rs1_data, load_val(1));
        check("fill x31", rs2_data, load_val(31));
        check("fill count", wb_count, 32'd31);

        @(negedge clk);
        drive(1'b0, 1'b1, 5'd4, 32'h0000_0077, 1'b1, 5'd4, 1'b1, 5'd4);
        #2;
        resetn = 1'b0;
        #1;
        check("async rs1", rs1_data, 32'h0);
        check("async rs2", rs2_data, 32'h0);
        check("async count", wb_count, 32'h0);
        @(posedge clk);
        #1;
        check("held rs1", rs1_data, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        resetn = 1'b1;

        for (int i = 1; i < 32; i += 2) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(i + 1));
            check($sformatf("cleared x%0d", i), rs1_data, 32'h0);
            check($sformatf("cleared x%0d", (i + 1) % 32), rs2_data, 32'h0);
        end
        check("post-reset count", wb_count, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
